// File: rtl/bc_ctrl_pkg.sv
// Shared encodings for the accumulator-CPU control sequencer: bus sources,
// strobe bit positions, ALU codes, opcodes and timing states.
package bc_ctrl_pkg;

  typedef enum logic [2:0] {
    T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
    T4 = 3'd4, T5 = 3'd5, T6 = 3'd6, HALT = 3'd7
  } state_t;

  localparam logic [2:0] SEL_NONE = 3'd0;
  localparam logic [2:0] SEL_AR   = 3'd1;
  localparam logic [2:0] SEL_PC   = 3'd2;
  localparam logic [2:0] SEL_DR   = 3'd3;
  localparam logic [2:0] SEL_AC   = 3'd4;
  localparam logic [2:0] SEL_IR   = 3'd5;
  localparam logic [2:0] SEL_TR   = 3'd6;
  localparam logic [2:0] SEL_MEM  = 3'd7;

  localparam int LD_AR = 5, LD_PC = 4, LD_DR = 3, LD_AC = 2, LD_IR = 1, LD_TR = 0;
  localparam int INC_AR = 3, INC_PC = 2, INC_DR = 1, INC_AC = 0;
  localparam int CLR_AR = 2, CLR_PC = 1, CLR_AC = 0;

  localparam logic [1:0] ALU_AND  = 2'd0;
  localparam logic [1:0] ALU_ADD  = 2'd1;
  localparam logic [1:0] ALU_PASS = 2'd2;
  localparam logic [1:0] ALU_CMA  = 2'd3;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_LDA  = 3'd2;
  localparam logic [2:0] OP_STA  = 3'd3;
  localparam logic [2:0] OP_BUN  = 3'd4;
  localparam logic [2:0] OP_BSA  = 3'd5;
  localparam logic [2:0] OP_ISZ  = 3'd6;
  localparam logic [2:0] OP_RREF = 3'd7;

  // register-reference bit positions within ir
  localparam int RR_CLA = 11, RR_CMA = 9, RR_INC = 5;
  localparam int RR_SPA = 4, RR_SNA = 3, RR_SZA = 2, RR_HLT = 0;

  typedef struct packed {
    logic [2:0] bus_sel;
    logic [5:0] load;
    logic [3:0] inc;
    logic [2:0] clr;
    logic [1:0] alu_op;
    logic       mem_we;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/bc_ctrl_decode.sv
// Combinational map of (timing state, IR, status flags) to datapath strobes
// and the next timing state.
module bc_ctrl_decode
  import bc_ctrl_pkg::*;
(
  input  state_t      state,
  input  logic [15:0] ir,
  input  logic        ac_zero,
  input  logic        ac_neg,
  input  logic        dr_zero,
  output ctrl_t       ctrl,
  output state_t      nxt
);

  logic       ind;
  logic [2:0] op;
  logic       skip;
  logic       unused;

  assign ind  = ir[15];
  assign op   = ir[14:12];
  assign skip = (ir[RR_SPA] & ~ac_neg & ~ac_zero) | (ir[RR_SNA] & ac_neg) |
                (ir[RR_SZA] & ac_zero);
  // NOP bits of the register-reference group
  assign unused = ^{ir[10], ir[8:6], ir[1]};

  always_comb begin
    ctrl = '0;
    nxt  = state;
    case (state)
      T0: begin
        ctrl.bus_sel      = SEL_PC;
        ctrl.load[LD_AR]  = 1'b1;
        nxt               = T1;
      end
      T1: begin
        ctrl.bus_sel      = SEL_MEM;
        ctrl.load[LD_IR]  = 1'b1;
        ctrl.inc[INC_PC]  = 1'b1;
        nxt               = T2;
      end
      T2: begin
        ctrl.bus_sel      = SEL_IR;
        ctrl.load[LD_AR]  = 1'b1;
        nxt               = T3;
      end
      T3: begin
        if (op == OP_RREF) begin
          if (!ind) begin
            if (ir[RR_CLA])      ctrl.clr[CLR_AC] = 1'b1;
            else if (ir[RR_CMA]) begin
              ctrl.alu_op      = ALU_CMA;
              ctrl.load[LD_AC] = 1'b1;
            end
            else if (ir[RR_INC]) ctrl.inc[INC_AC] = 1'b1;
            ctrl.inc[INC_PC] = skip;
            nxt = ir[RR_HLT] ? HALT : T0;
          end else begin
            ctrl.illegal = 1'b1;
            nxt          = T0;
          end
        end else if (ind) begin
          ctrl.bus_sel     = SEL_MEM;
          ctrl.load[LD_AR] = 1'b1;
          nxt              = T4;
        end else begin
          nxt = T4;
        end
      end
      T4: begin
        case (op)
          OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
            ctrl.bus_sel     = SEL_MEM;
            ctrl.load[LD_DR] = 1'b1;
            nxt              = T5;
          end
          OP_STA: begin
            ctrl.bus_sel = SEL_AC;
            ctrl.mem_we  = 1'b1;
            nxt          = T0;
          end
          OP_BUN: begin
            ctrl.bus_sel     = SEL_AR;
            ctrl.load[LD_PC] = 1'b1;
            nxt              = T0;
          end
          OP_BSA: begin
            ctrl.bus_sel     = SEL_PC;
            ctrl.mem_we      = 1'b1;
            ctrl.inc[INC_AR] = 1'b1;
            nxt              = T5;
          end
          default: nxt = T0;
        endcase
      end
      T5: begin
        case (op)
          OP_AND: begin ctrl.alu_op = ALU_AND;  ctrl.load[LD_AC] = 1'b1; nxt = T0; end
          OP_ADD: begin ctrl.alu_op = ALU_ADD;  ctrl.load[LD_AC] = 1'b1; nxt = T0; end
          OP_LDA: begin ctrl.alu_op = ALU_PASS; ctrl.load[LD_AC] = 1'b1; nxt = T0; end
          OP_BSA: begin
            ctrl.bus_sel     = SEL_AR;
            ctrl.load[LD_PC] = 1'b1;
            nxt              = T0;
          end
          OP_ISZ: begin ctrl.inc[INC_DR] = 1'b1; nxt = T6; end
          default: nxt = T0;
        endcase
      end
      T6: begin
        // dr_zero already reflects the DR incremented in T5
        ctrl.bus_sel     = SEL_DR;
        ctrl.mem_we      = 1'b1;
        ctrl.inc[INC_PC] = dr_zero;
        nxt              = T0;
      end
      HALT:    nxt = HALT;
      default: nxt = T0;
    endcase
  end

endmodule

// File: rtl/bc_control_seq.sv
// Hardwired fetch/decode/execute sequencer: timing-state register plus the
// combinational strobe decoder. Strobes are forced low while rst is high.
module bc_control_seq
  import bc_ctrl_pkg::*;
#(
  parameter bit AUTO_START = 1'b1,
  parameter int ADDR_W     = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] ir,
  input  logic        ac_zero,
  input  logic        ac_neg,
  input  logic        dr_zero,
  output logic [2:0]  bus_sel,
  output logic [5:0]  load,
  output logic [3:0]  inc,
  output logic [2:0]  clr,
  output logic [1:0]  alu_op,
  output logic        mem_we,
  output logic        running,
  output logic [2:0]  sc,
  output logic        illegal
);

  localparam state_t RST_ST = AUTO_START ? T0 : HALT;

  state_t            state, nxt;
  ctrl_t             ctrl;
  logic [ADDR_W-1:0] unused_addr;

  // the operand address field is consumed by the datapath, not here
  assign unused_addr = ir[ADDR_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          state <= RST_ST;
    else if (state == HALT && start)  state <= T0;
    else                              state <= nxt;
  end

  bc_ctrl_decode u_dec (
    .state   (state),
    .ir      (ir),
    .ac_zero (ac_zero),
    .ac_neg  (ac_neg),
    .dr_zero (dr_zero),
    .ctrl    (ctrl),
    .nxt     (nxt)
  );

  always_comb begin
    {bus_sel, load, inc, clr, alu_op, mem_we, illegal} = '0;
    if (!rst) {bus_sel, load, inc, clr, alu_op, mem_we, illegal} = ctrl;
  end

  assign running = !rst && (state != HALT);
  assign sc      = state;

endmodule

// File: tb/tb_bc_control_seq.sv
// Directed bench: a behavioural accumulator-CPU datapath driven by the
// sequencer's strobes, with hand-computed expected register/memory contents.
module tb_bc_control_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  bus_sel;
  logic [5:0]  load;
  logic [3:0]  inc;
  logic [2:0]  clr;
  logic [1:0]  alu_op;
  logic        mem_we, running, illegal;
  logic [2:0]  sc;

  logic [11:0] ar, pc;
  logic [15:0] dr, ac, ir, tr, bus, alu;
  logic [15:0] mem [0:4095];
  logic [15:0] ac_init = '0;
  logic        pl_we = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [15:0] pl_data = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bc_control_seq #(.AUTO_START(1'b1), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .start(start), .ir(ir),
    .ac_zero(ac == 16'h0), .ac_neg(ac[15]), .dr_zero(dr == 16'h0),
    .bus_sel(bus_sel), .load(load), .inc(inc), .clr(clr), .alu_op(alu_op),
    .mem_we(mem_we), .running(running), .sc(sc), .illegal(illegal)
  );

  always_comb begin
    case (bus_sel)
      3'd1:    bus = {4'h0, ar};
      3'd2:    bus = {4'h0, pc};
      3'd3:    bus = dr;
      3'd4:    bus = ac;
      3'd5:    bus = ir;
      3'd6:    bus = tr;
      3'd7:    bus = mem[ar];
      default: bus = 16'h0;
    endcase
    case (alu_op)
      2'd0:    alu = ac & dr;
      2'd1:    alu = ac + dr;
      2'd2:    alu = dr;
      default: alu = ~ac;
    endcase
  end

  always @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      ac <= ac_init;
      if (pl_we) mem[pl_addr] <= pl_data;
    end else begin
      if (load[5]) ar <= bus[11:0]; else if (inc[3]) ar <= ar + 1'b1; else if (clr[2]) ar <= '0;
      if (load[4]) pc <= bus[11:0]; else if (inc[2]) pc <= pc + 1'b1; else if (clr[1]) pc <= '0;
      if (load[3]) dr <= bus; else if (inc[1]) dr <= dr + 1'b1;
      if (clr[0]) ac <= '0; else if (load[2]) ac <= alu; else if (inc[0]) ac <= ac + 1'b1;
      if (load[1]) ir <= bus;
      if (load[0]) tr <= bus;
      if (mem_we)  mem[ar] <= bus;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // enter reset at a negedge; pokes then happen while rst is held
  task automatic hold_rst(input logic [15:0] acv);
    @(negedge clk);
    rst = 1'b1;
    ac_init = acv;
  endtask

  task automatic poke(input logic [11:0] a, input logic [15:0] d);
    pl_addr = a; pl_data = d; pl_we = 1'b1;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic go;
    rst = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [2:0] exp_sc [0:6];

  initial begin
    exp_sc = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};

    // LDA 4 with reset-state checks
    hold_rst(16'h0000);
    poke(12'h000, 16'h2004); poke(12'h001, 16'h7001); poke(12'h004, 16'h1234);
    #1;
    chk("rst_strobes", {bus_sel, load, inc, clr, alu_op, mem_we, illegal}, 0);
    chk("rst_running", running, 1'b0);
    go(); #1;
    chk("lda_sc0", sc, exp_sc[0]);
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      chk($sformatf("lda_sc%0d", k), sc, exp_sc[k]);
    end
    chk("lda_ac", ac, 16'h1234);
    chk("lda_pc", pc, 12'h001);

    // indirect ADD
    hold_rst(16'h0001);
    poke(12'h000, 16'h9005); poke(12'h001, 16'h7001);
    poke(12'h005, 16'h0006); poke(12'h006, 16'h0010);
    go(); cyc(3);
    chk("ind_t3_sel", bus_sel, 3'd7);
    chk("ind_t3_load", load, 6'b100000);
    cyc(1);
    chk("ind_t4_ar", ar, 12'h006);
    cyc(2);
    chk("ind_ac", ac, 16'h0011);

    // STA then BSA
    hold_rst(16'hBEEF);
    poke(12'h000, 16'h3008); poke(12'h001, 16'h5010); poke(12'h008, 16'h0000);
    poke(12'h010, 16'h0000); poke(12'h011, 16'h7001);
    go(); cyc(11);
    chk("sta_mem", mem[8], 16'hBEEF);
    chk("bsa_mem", mem[16], 16'h0002);
    chk("bsa_pc", pc, 12'h011);

    // ISZ with and without skip
    hold_rst(16'h0000);
    poke(12'h000, 16'h6007); poke(12'h001, 16'h7001); poke(12'h002, 16'h7001);
    poke(12'h007, 16'hFFFF);
    go(); cyc(7);
    chk("isz_wrap_mem", mem[7], 16'h0000);
    chk("isz_wrap_pc", pc, 12'h002);
    hold_rst(16'h0000);
    poke(12'h007, 16'h0003);
    go(); cyc(7);
    chk("isz_mem", mem[7], 16'h0004);
    chk("isz_pc", pc, 12'h001);

    // SZA skip, HLT, start resume
    hold_rst(16'h0000);
    poke(12'h000, 16'h7004); poke(12'h002, 16'h7001); poke(12'h003, 16'h7001);
    go(); cyc(4);
    chk("sza_pc", pc, 12'h002);
    cyc(4);
    chk("hlt_running", running, 1'b0);
    chk("hlt_sc", sc, 3'd7);
    chk("hlt_strobes", {bus_sel, load, inc, clr, alu_op, mem_we, illegal}, 0);
    chk("hlt_pc", pc, 12'h003);
    cyc(2);
    chk("hlt_stays", sc, 3'd7);
    start = 1'b1; cyc(1); start = 1'b0;
    chk("start_sc", sc, 3'd0);
    chk("start_running", running, 1'b1);
    cyc(2);
    chk("resume_ir", ir, 16'h7001);
    chk("resume_pc", pc, 12'h004);

    // CMA, and CLA winning over CMA
    hold_rst(16'h00FF);
    poke(12'h000, 16'h7200); poke(12'h001, 16'h7A01);
    go(); cyc(4);
    chk("cma_ac", ac, 16'hFF00);
    cyc(4);
    chk("cla_prio_ac", ac, 16'h0000);

    // reset during T4 of STA suppresses the write
    hold_rst(16'hBEEF);
    poke(12'h000, 16'h3008); poke(12'h008, 16'h5555);
    go(); cyc(4);
    chk("abort_t4_sc", sc, 3'd4);
    rst = 1'b1; #1;
    chk("abort_we", mem_we, 1'b0);
    chk("abort_state", sc, 3'd0);
    cyc(2);
    chk("abort_mem", mem[8], 16'h5555);
    go(); #1;
    chk("abort_restart_sel", bus_sel, 3'd2);

    // illegal opcode pulses once
    hold_rst(16'h0000);
    poke(12'h000, 16'hF000); poke(12'h001, 16'h7001);
    go(); cyc(2);
    chk("ill_t2", illegal, 1'b0);
    cyc(1);
    chk("ill_t3", illegal, 1'b1);
    cyc(1);
    chk("ill_after", illegal, 1'b0);
    chk("ill_sc", sc, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
